// File: rtl/fetch_prefetch_queue_if.sv
// Fetch queue port bundle: instruction-memory request/response side and the decode-facing side.
// Latency: none, wires only.
// Backpressure: StallD holds the head entry; imem_gnt holds the pending request.
interface fetch_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // instruction memory side
  logic          imem_req;
  logic [15:0]   imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [15:0]   imem_rdata;

  // pipeline control side
  logic          StallD;
  logic          redirect;
  logic [15:0]   redirect_pc;

  // decode side
  logic          inst_valid;
  logic [15:0]   inst_out;
  logic [15:0]   inst_pc;
  logic [CW-1:0] fq_count;

  // the fetch queue itself
  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc, fq_count,
    input  imem_gnt, imem_rvalid, imem_rdata, StallD, redirect, redirect_pc
  );

  // memory plus pipeline environment around the fetch queue
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, fq_count,
    output imem_gnt, imem_rvalid, imem_rdata, StallD, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: in-order reads to variable-latency imem, words+PCs buffered for decode.
// Latency: gnt at T, rvalid at T+k -> inst_valid at T+k+1 (same cycle T+k into an empty queue with FQ_BYPASS_EN).
// Backpressure: StallD holds the head; requests stop once queued + in-flight words reach DEPTH.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_prefetch_queue_if.master fq
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = PW + 1;
  localparam int          CW1     = CW + 1;
  localparam logic [CW:0] DEPTH_W = CW1'(DEPTH);

  // architectural state
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   resp_pc_q,  resp_pc_d;
  logic [CW-1:0] count_q,    count_d;
  logic [CW-1:0] outst_q,    outst_d;
  logic [CW-1:0] discard_q,  discard_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;

  // entry storage, written only on push, never reset
  logic [15:0]   inst_mem_q [DEPTH];
  logic [15:0]   pc_mem_q   [DEPTH];

  // handshake qualifiers
  logic [CW:0]   inflight;
  logic          req;
  logic          hs;
  logic          rsp;
  logic          drop;
  logic          accept;

  // queue control and decode-facing values
  logic          head_vld;
  logic          byp_vld;
  logic          byp_take;
  logic          push;
  logic          pop;
  logic          out_vld;
  logic [15:0]   out_inst;
  logic [15:0]   out_pc;

  // Request gating and classification of the returning word
  always_comb begin
    inflight = {1'b0, count_q} + {1'b0, outst_q};
    // queued plus in-flight words never exceed DEPTH, so a push can never find the queue full
    req      = !rst && !fq.redirect && (inflight < DEPTH_W);
    hs       = req && fq.imem_gnt;
    // an rvalid with nothing in flight is stray (e.g. from before a reset) and is ignored
    rsp      = fq.imem_rvalid && (outst_q != '0);
    drop     = rsp && (discard_q != '0);
    // the word arriving in a redirect cycle belongs to the old stream and is dropped
    accept   = rsp && (discard_q == '0) && !fq.redirect;
  end

  // Head selection, optional same-cycle bypass, push/pop decisions
  always_comb begin
    head_vld = !rst && (count_q != '0);
    byp_vld  = 1'b0;
    byp_take = 1'b0;
`ifdef FQ_BYPASS_EN
    // accept already excludes the redirect cycle, so bypass is inactive there too
    byp_vld  = !rst && (count_q == '0) && accept;
    byp_take = byp_vld && !fq.StallD;
`endif
    out_vld  = head_vld || byp_vld;
    out_inst = 16'h0000;
    out_pc   = 16'h0000;
    if (head_vld) begin
      out_inst = inst_mem_q[rd_ptr_q];
      out_pc   = pc_mem_q[rd_ptr_q];
    end else if (byp_vld) begin
      out_inst = fq.imem_rdata;
      out_pc   = resp_pc_q;
    end
    pop  = head_vld && !fq.StallD;
    // a bypassed word consumed by decode is never written into the queue
    push = accept && !byp_take;
  end

  // Next-state: fetch/response PCs, occupancy, in-flight and discard counters, pointers
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (hs) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
    // resp_pc tracks every accepted word, including one consumed through the bypass
    if (accept) begin
      resp_pc_d = resp_pc_q + PC_STEP;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({hs, rsp})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
    if (drop) begin
      discard_d = discard_q - CW'(1);
    end

    // Redirect flushes the queue; every read still in flight after this cycle
    // belongs to the old path, so discard simply equals the new outstanding count
    // (req is low here, so no gnt is counted; a response this cycle retires one).
    if (fq.redirect) begin
      fetch_pc_d = fq.redirect_pc;
      resp_pc_d  = fq.redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      discard_d  = outst_d;
    end
  end

  // State register with synchronous reset; drops every in-flight read
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Entry write on push: instruction word with the PC it was fetched from
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      inst_mem_q[wr_ptr_q] <= fq.imem_rdata;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assign fq.imem_req   = req;
  assign fq.imem_addr  = fetch_pc_q;
  assign fq.inst_valid = out_vld;
  assign fq.inst_out   = out_inst;
  assign fq.inst_pc    = out_pc;
  assign fq.fq_count   = rst ? '0 : count_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: per-cycle input vectors with hand-derived outputs.
// Inputs change on negedge; outputs are compared 1 ns later, well before the next posedge.
// The full suite targets the default build; a bypass build runs reset plus the bypass sequence.
module tb_fetch_prefetch_queue;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic [15:0] rdata;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_vld;
    logic [15:0] e_inst;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t tbl[$];

  fetch_prefetch_queue_if #(.DEPTH(4)) fq_if ();

  fetch_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (16'h0000),
    .PC_STEP  (16'd2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic g, input logic v, input logic [15:0] d,
                              input logic s, input logic rd, input logic [15:0] rp,
                              input logic er, input logic [15:0] ea, input logic ev,
                              input logic [15:0] ei, input logic [15:0] ep, input logic [2:0] ec);
    vec_t x;
    x.rst = r;  x.gnt = g;  x.rv = v;  x.rdata = d;  x.stall = s;  x.redir = rd;  x.rpc = rp;
    x.e_req = er;  x.e_addr = ea;  x.e_vld = ev;  x.e_inst = ei;  x.e_pc = ep;  x.e_cnt = ec;
    return x;
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then compare every output of that cycle
  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    rst                = v.rst;
    fq_if.imem_gnt     = v.gnt;
    fq_if.imem_rvalid  = v.rv;
    fq_if.imem_rdata   = v.rdata;
    fq_if.StallD       = v.stall;
    fq_if.redirect     = v.redir;
    fq_if.redirect_pc  = v.rpc;
    #1;
    cmp({nm, ".req"}, {15'd0, fq_if.imem_req}, {15'd0, v.e_req});
    if (v.e_req) cmp({nm, ".addr"}, fq_if.imem_addr, v.e_addr);
    cmp({nm, ".vld"},  {15'd0, fq_if.inst_valid}, {15'd0, v.e_vld});
    cmp({nm, ".inst"}, fq_if.inst_out, v.e_inst);
    cmp({nm, ".pc"},   fq_if.inst_pc, v.e_pc);
    cmp({nm, ".cnt"},  {13'd0, fq_if.fq_count}, {13'd0, v.e_cnt});
    // occupancy must never exceed DEPTH (a push into a full queue)
    checks++;
    if (fq_if.fq_count > 3'd4) begin
      errors++;
      $display("FAIL %s.bound: fq_count %0d, limit 4", nm, fq_if.fq_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    fq_if.imem_gnt = 1'b0;  fq_if.imem_rvalid = 1'b0;  fq_if.imem_rdata = 16'h0000;
    fq_if.StallD = 1'b0;    fq_if.redirect = 1'b0;     fq_if.redirect_pc = 16'h0000;

`ifndef FQ_BYPASS_EN
    // Reset, 1-cycle memory, back-to-back flow; then StallD fills the queue and releases
    tbl.push_back(mk(1,1,1,16'hFFFF,0,0,0, 0,16'h0000,0,16'h0000,16'h0000,0));
    tbl.push_back(mk(1,1,1,16'hFFFF,0,0,0, 0,16'h0000,0,16'h0000,16'h0000,0));
    tbl.push_back(mk(0,1,0,16'h0000,0,0,0, 1,16'h0000,0,16'h0000,16'h0000,0));
    tbl.push_back(mk(0,1,1,16'hA000,0,0,0, 1,16'h0002,0,16'h0000,16'h0000,0));
    tbl.push_back(mk(0,1,1,16'hA002,0,0,0, 1,16'h0004,1,16'hA000,16'h0000,1));
    tbl.push_back(mk(0,1,1,16'hA004,0,0,0, 1,16'h0006,1,16'hA002,16'h0002,1));
    tbl.push_back(mk(0,1,1,16'hA006,1,0,0, 1,16'h0008,1,16'hA004,16'h0004,1));
    tbl.push_back(mk(0,1,1,16'hA008,1,0,0, 1,16'h000A,1,16'hA004,16'h0004,2));
    tbl.push_back(mk(0,1,1,16'hA00A,1,0,0, 0,16'h0000,1,16'hA004,16'h0004,3));
    tbl.push_back(mk(0,1,0,16'h0000,1,0,0, 0,16'h0000,1,16'hA004,16'h0004,4));
    tbl.push_back(mk(0,1,0,16'h0000,1,0,0, 0,16'h0000,1,16'hA004,16'h0004,4));
    tbl.push_back(mk(0,1,0,16'h0000,0,0,0, 0,16'h0000,1,16'hA004,16'h0004,4));
    tbl.push_back(mk(0,1,0,16'h0000,0,0,0, 1,16'h000C,1,16'hA006,16'h0006,3));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,0, 1,16'h000E,1,16'hA008,16'h0008,2));
    tbl.push_back(mk(0,0,1,16'hA00C,0,0,0, 1,16'h000E,1,16'hA00A,16'h000A,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,0, 1,16'h000E,1,16'hA00C,16'h000C,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,0, 1,16'h000E,0,16'h0000,16'h0000,0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("flow%0d", i));

    // Redirect with three reads in flight at latency 5: all three responses dropped
    step(mk(1,0,0,16'h0000,0,0,0,        0,16'h0000,0,16'h0000,16'h0000,0), "rd3.rst");
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'h0000,0,16'h0000,16'h0000,0), "rd3.g0");
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'h0002,0,16'h0000,16'h0000,0), "rd3.g1");
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'h0004,0,16'h0000,16'h0000,0), "rd3.g2");
    step(mk(0,1,0,16'h0000,0,1,16'h0100, 0,16'h0000,0,16'h0000,16'h0000,0), "rd3.redir");
    step(mk(0,0,0,16'h0000,0,0,0,        1,16'h0100,0,16'h0000,16'h0000,0), "rd3.idle");
    step(mk(0,0,1,16'hD000,0,0,0,        1,16'h0100,0,16'h0000,16'h0000,0), "rd3.drop0");
    step(mk(0,0,1,16'hD002,0,0,0,        1,16'h0100,0,16'h0000,16'h0000,0), "rd3.drop1");
    step(mk(0,0,1,16'hD004,0,0,0,        1,16'h0100,0,16'h0000,16'h0000,0), "rd3.drop2");
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'h0100,0,16'h0000,16'h0000,0), "rd3.g3");
    step(mk(0,0,1,16'hB100,0,0,0,        1,16'h0102,0,16'h0000,16'h0000,0), "rd3.rv");
    step(mk(0,0,0,16'h0000,0,0,0,        1,16'h0102,1,16'hB100,16'h0100,1), "rd3.first");
    step(mk(0,0,0,16'h0000,0,0,0,        1,16'h0102,0,16'h0000,16'h0000,0), "rd3.empty");

    // Redirect coinciding with rvalid and gnt; redirect over a held head; stray rvalid
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'h0102,0,16'h0000,16'h0000,0), "rdx.g0");
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'h0104,0,16'h0000,16'h0000,0), "rdx.g1");
    step(mk(0,1,1,16'hEEEE,0,1,16'h0200, 0,16'h0000,0,16'h0000,16'h0000,0), "rdx.redir");
    step(mk(0,0,1,16'hEEEF,0,0,0,        1,16'h0200,0,16'h0000,16'h0000,0), "rdx.drop");
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'h0200,0,16'h0000,16'h0000,0), "rdx.g2");
    step(mk(0,0,1,16'hC200,0,0,0,        1,16'h0202,0,16'h0000,16'h0000,0), "rdx.rv");
    step(mk(0,0,0,16'h0000,1,0,0,        1,16'h0202,1,16'hC200,16'h0200,1), "rdx.hold");
    step(mk(0,0,0,16'h0000,1,1,16'h0300, 0,16'h0000,1,16'hC200,16'h0200,1), "rdx.flush");
    step(mk(0,0,0,16'h0000,0,0,0,        1,16'h0300,0,16'h0000,16'h0000,0), "rdx.after");
    step(mk(0,0,1,16'h7777,0,0,0,        1,16'h0300,0,16'h0000,16'h0000,0), "rdx.stray");
    step(mk(0,0,0,16'h0000,0,0,0,        1,16'h0300,0,16'h0000,16'h0000,0), "rdx.stray2");

    // PC wrap at 16 bits
    step(mk(0,0,0,16'h0000,0,1,16'hFFFE, 0,16'h0000,0,16'h0000,16'h0000,0), "wrap.redir");
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'hFFFE,0,16'h0000,16'h0000,0), "wrap.g0");
    step(mk(0,1,1,16'hF0FE,0,0,0,        1,16'h0000,0,16'h0000,16'h0000,0), "wrap.g1");
    step(mk(0,0,1,16'hF000,0,0,0,        1,16'h0002,1,16'hF0FE,16'hFFFE,1), "wrap.i0");
    step(mk(0,0,0,16'h0000,0,0,0,        1,16'h0002,1,16'hF000,16'h0000,1), "wrap.i1");
    step(mk(0,0,0,16'h0000,0,0,0,        1,16'h0002,0,16'h0000,16'h0000,0), "wrap.empty");

    // Reset while a read is in flight: its late rvalid is ignored
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'h0002,0,16'h0000,16'h0000,0), "mrst.g");
    step(mk(1,0,1,16'h9999,0,0,0,        0,16'h0000,0,16'h0000,16'h0000,0), "mrst.rst");
    step(mk(0,0,1,16'h9999,0,0,0,        1,16'h0000,0,16'h0000,16'h0000,0), "mrst.stray");
    step(mk(0,0,0,16'h0000,0,0,0,        1,16'h0000,0,16'h0000,16'h0000,0), "mrst.idle");
`endif

    // Word returning into an empty queue, with and without StallD; redirect-cycle rvalid
    step(mk(1,0,0,16'h0000,0,0,0,        0,16'h0000,0,16'h0000,16'h0000,0), "byp.rst");
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'h0000,0,16'h0000,16'h0000,0), "byp.g0");
`ifdef FQ_BYPASS_EN
    step(mk(0,0,1,16'hA5C3,0,0,0,        1,16'h0002,1,16'hA5C3,16'h0000,0), "byp.rv0");
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'h0002,0,16'h0000,16'h0000,0), "byp.g1");
    step(mk(0,0,1,16'h5A3C,1,0,0,        1,16'h0004,1,16'h5A3C,16'h0002,0), "byp.rv1");
`else
    step(mk(0,0,1,16'hA5C3,0,0,0,        1,16'h0002,0,16'h0000,16'h0000,0), "byp.rv0");
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'h0002,1,16'hA5C3,16'h0000,1), "byp.g1");
    step(mk(0,0,1,16'h5A3C,1,0,0,        1,16'h0004,0,16'h0000,16'h0000,0), "byp.rv1");
`endif
    step(mk(0,0,0,16'h0000,0,0,0,        1,16'h0004,1,16'h5A3C,16'h0002,1), "byp.held");
    step(mk(0,0,0,16'h0000,0,0,0,        1,16'h0004,0,16'h0000,16'h0000,0), "byp.empty");
    step(mk(0,1,0,16'h0000,0,0,0,        1,16'h0004,0,16'h0000,16'h0000,0), "byp.g2");
    step(mk(0,0,1,16'h1111,0,1,16'h0400, 0,16'h0000,0,16'h0000,16'h0000,0), "byp.redir");
    step(mk(0,0,0,16'h0000,0,0,0,        1,16'h0400,0,16'h0000,16'h0000,0), "byp.after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
